// File: rtl/load_unit_pkg.sv
// rtl/load_unit_pkg.sv - shared memory-op encodings, bus sizes and load FSM state type
package load_unit_pkg;

  // Memory operation codes; loads and stores share one encoding space
  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_t;

  // Access size presented on the data bus
  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  // Load unit controller states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } load_state_t;

  function automatic logic is_load(input mem_t t);
    return (t == MEM_LB) || (t == MEM_LBU) || (t == MEM_LH) ||
           (t == MEM_LHU) || (t == MEM_LW);
  endfunction

  function automatic msize_t load_size(input mem_t t);
    case (t)
      MEM_LB, MEM_LBU: return MSIZE1;
      MEM_LH, MEM_LHU: return MSIZE2;
      default:         return MSIZE4;
    endcase
  endfunction

  // Halfwords must be 2-byte aligned, words 4-byte aligned
  function automatic logic is_misaligned(input mem_t t, input logic [1:0] lo);
    case (t)
      MEM_LH, MEM_LHU: return lo[0];
      MEM_LW:          return lo != 2'b00;
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_unit_if.sv
// rtl/load_unit_if.sv - load request, data bus and result signals of the load unit
interface load_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import load_unit_pkg::*;

  // memory stage request
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  mem_t              ld_type;

  // data bus request / response
  logic              dreq_valid;
  logic [ADDR_W-1:0] dreq_addr;
  msize_t            dreq_size;
  logic              dresp_addr_ok;
  logic              dresp_data_ok;
  logic [DATA_W-1:0] dresp_data;

  // load result towards the pipeline
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_err;

  // Environment side: memory stage, data bus and result consumer
  modport master (
    output ld_valid, ld_addr, ld_type,
    output dresp_addr_ok, dresp_data_ok, dresp_data,
    output rd_ready,
    input  ld_ready, dreq_valid, dreq_addr, dreq_size,
    input  rd_valid, rd_data, rd_err
  );

  // Load unit side
  modport slave (
    input  ld_valid, ld_addr, ld_type,
    input  dresp_addr_ok, dresp_data_ok, dresp_data,
    input  rd_ready,
    output ld_ready, dreq_valid, dreq_addr, dreq_size,
    output rd_valid, rd_data, rd_err
  );

endinterface

// File: rtl/load_unit_extract.sv
// rtl/load_unit_extract.sv - load_extract: selects and extends the addressed byte/halfword of a word lane
module load_extract
  import load_unit_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  mem_t        mem_type,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by sign/zero extension; halfword uses addr[1] only
  always_comb begin
    byte_sel = word[7:0];
    case (addr_lo)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    data = '0;
    case (mem_type)
      MEM_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: data = {24'd0, byte_sel};
      MEM_LH:  data = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: data = {16'd0, half_sel};
      MEM_LW:  data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// rtl/load_unit.sv - single-outstanding load unit (optional LOAD_MISALIGN_CHECK_EN address check)
module load_unit
  import load_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input logic        clk,
  input logic        reset,
  input logic        flush,
  load_unit_if.slave bus
);

  load_state_t       state;
  logic [ADDR_W-1:0] addr_q;
  mem_t              type_q;
  logic              ld_ready_q;
  logic              dreq_valid_q;
  logic              rd_valid_q;
  logic              rd_err_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] ext_data;
  logic              accept;
  logic              misalign;

  load_extract u_extract (
    .addr_lo  (addr_q[1:0]),
    .mem_type (type_q),
    .word     (bus.dresp_data),
    .data     (ext_data)
  );

  assign accept = bus.ld_valid && is_load(bus.ld_type) && !flush;

`ifdef LOAD_MISALIGN_CHECK_EN
  assign misalign = is_misaligned(bus.ld_type, bus.ld_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign bus.ld_ready   = ld_ready_q;
  assign bus.dreq_valid = dreq_valid_q;
  assign bus.dreq_addr  = addr_q;
  assign bus.dreq_size  = load_size(type_q);
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_err     = rd_err_q;

  // Load controller: request issue, response capture, result hold and flush draining
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      addr_q       <= '0;
      type_q       <= MEM_NONE;
      ld_ready_q   <= 1'b1;
      dreq_valid_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_err_q     <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            addr_q     <= bus.ld_addr;
            type_q     <= bus.ld_type;
            ld_ready_q <= 1'b0;
            if (misalign) begin
              state      <= ST_HOLD;
              rd_valid_q <= 1'b1;
              rd_err_q   <= 1'b1;
              rd_data_q  <= '0;
            end else begin
              state        <= ST_ADDR;
              dreq_valid_q <= 1'b1;
            end
          end
        end
        ST_ADDR: begin
          if (flush) begin
            dreq_valid_q <= 1'b0;
            if (bus.dresp_addr_ok && !bus.dresp_data_ok) begin
              // address already taken by the bus: its data must still be absorbed
              state <= ST_DRAIN;
            end else begin
              state      <= ST_IDLE;
              ld_ready_q <= 1'b1;
            end
          end else if (bus.dresp_addr_ok) begin
            dreq_valid_q <= 1'b0;
            if (bus.dresp_data_ok) begin
              state      <= ST_HOLD;
              rd_valid_q <= 1'b1;
              rd_err_q   <= 1'b0;
              rd_data_q  <= ext_data;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (bus.dresp_data_ok) begin
            if (flush) begin
              state      <= ST_IDLE;
              ld_ready_q <= 1'b1;
            end else begin
              state      <= ST_HOLD;
              rd_valid_q <= 1'b1;
              rd_err_q   <= 1'b0;
              rd_data_q  <= ext_data;
            end
          end else if (flush) begin
            state <= ST_DRAIN;
          end
        end
        ST_HOLD: begin
          if (flush || bus.rd_ready) begin
            state      <= ST_IDLE;
            ld_ready_q <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (bus.dresp_data_ok) begin
            state      <= ST_IDLE;
            ld_ready_q <= 1'b1;
          end
        end
        default: begin
          state        <= ST_IDLE;
          ld_ready_q   <= 1'b1;
          dreq_valid_q <= 1'b0;
          rd_valid_q   <= 1'b0;
          rd_err_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// tb/tb_load_unit.sv - randomized self-checking bench for load_unit against a behavioural load model
module tb_load_unit;
  import load_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   total = 0;
  int   bad = 0;

  load_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  load_unit #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference: value a load returns for word w at byte address a
  function automatic logic [31:0] model_data(input logic [31:0] a, input mem_t t, input logic [31:0] w);
    int unsigned v;
    int unsigned lo;
    lo = a % 4;
    case (t)
      MEM_LB, MEM_LBU: begin
        v = (w >> (8 * lo)) % 256;
        if (t == MEM_LB && v >= 128) v = v - 256;
      end
      MEM_LH, MEM_LHU: begin
        v = (w >> (16 * (lo / 2))) % 65536;
        if (t == MEM_LH && v >= 32768) v = v - 65536;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic msize_t model_size(input mem_t t);
    if (t == MEM_LB || t == MEM_LBU) return MSIZE1;
    if (t == MEM_LH || t == MEM_LHU) return MSIZE2;
    return MSIZE4;
  endfunction

  function automatic logic model_bad(input logic [31:0] a, input mem_t t);
`ifdef LOAD_MISALIGN_CHECK_EN
    return ((t == MEM_LH || t == MEM_LHU) && (a % 2 != 0)) || (t == MEM_LW && (a % 4 != 0));
`else
    return 1'b0;
`endif
  endfunction

  // One complete load with chosen bus/consumer delays; called at a negedge with the unit idle
  task automatic run_load(input string tag, input logic [31:0] a, input mem_t t,
                          input logic [31:0] w, input logic [31:0] exp,
                          input int aok_wait, input int dok_gap, input int rdy_wait);
    logic        err_exp;
    logic [31:0] data_exp;
    err_exp  = model_bad(a, t);
    data_exp = err_exp ? 32'd0 : exp;
    chk({tag, ".ready0"}, bus.ld_ready, 1);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = a;
    bus.ld_type  = t;
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_addr  = $urandom;
    chk({tag, ".busy"}, bus.ld_ready, 0);
    if (err_exp) begin
      chk({tag, ".noreq"}, bus.dreq_valid, 0);
    end else begin
      chk({tag, ".rv_early"}, bus.rd_valid, 0);
      chk({tag, ".dreq"}, bus.dreq_valid, 1);
      chk({tag, ".daddr"}, bus.dreq_addr, a);
      chk({tag, ".dsize"}, 32'(bus.dreq_size), 32'(model_size(t)));
      for (int i = 0; i < aok_wait; i++) begin
        tick();
        chk({tag, ".dreq_hold"}, bus.dreq_valid, 1);
        chk({tag, ".daddr_hold"}, bus.dreq_addr, a);
      end
      bus.dresp_addr_ok = 1'b1;
      bus.dresp_data_ok = (dok_gap == 0);
      bus.dresp_data    = (dok_gap == 0) ? w : $urandom;
      tick();
      bus.dresp_addr_ok = 1'b0;
      bus.dresp_data_ok = 1'b0;
      if (dok_gap > 0) begin
        chk({tag, ".dreq_low"}, bus.dreq_valid, 0);
        chk({tag, ".rv_wait"}, bus.rd_valid, 0);
        for (int i = 1; i < dok_gap; i++) begin
          bus.dresp_data = $urandom;
          tick();
          chk({tag, ".dreq_low2"}, bus.dreq_valid, 0);
        end
        bus.dresp_data_ok = 1'b1;
        bus.dresp_data    = w;
        tick();
        bus.dresp_data_ok = 1'b0;
      end
      bus.dresp_data = $urandom;
    end
    chk({tag, ".rv"}, bus.rd_valid, 1);
    chk({tag, ".rdata"}, bus.rd_data, data_exp);
    chk({tag, ".rerr"}, bus.rd_err, 32'(err_exp));
    for (int i = 0; i < rdy_wait; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_type  = MEM_LW;
      tick();
      chk({tag, ".rv_hold"}, bus.rd_valid, 1);
      chk({tag, ".rdata_hold"}, bus.rd_data, data_exp);
      chk({tag, ".busy_hold"}, bus.ld_ready, 0);
    end
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    bus.ld_valid = 1'b0;
    chk({tag, ".rv_drop"}, bus.rd_valid, 0);
    chk({tag, ".ready1"}, bus.ld_ready, 1);
    chk({tag, ".no_new_req"}, bus.dreq_valid, 0);
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    bus.ld_valid      = 1'b0;
    bus.ld_addr       = '0;
    bus.ld_type       = MEM_NONE;
    bus.dresp_addr_ok = 1'b0;
    bus.dresp_data_ok = 1'b0;
    bus.dresp_data    = '0;
    bus.rd_ready      = 1'b0;
    tick();
    tick();
    chk("rst.ready", bus.ld_ready, 1);
    chk("rst.dreq", bus.dreq_valid, 0);
    chk("rst.rv", bus.rd_valid, 0);
    chk("rst.rerr", bus.rd_err, 0);
    chk("rst.rdata", bus.rd_data, 0);
    chk("rst.daddr", bus.dreq_addr, 0);
    reset = 1'b0;
    tick();

    // Directed loads from the plan
    run_load("lb", 32'h0000_1003, MEM_LB, 32'h8011_2233, 32'hFFFF_FF80, 0, 0, 0);
    run_load("lhu", 32'h0000_2002, MEM_LHU, 32'hBEEF_1234, 32'h0000_BEEF, 0, 3, 0);
    run_load("lw", 32'h0000_3000, MEM_LW, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 1, 3);
    run_load("lh", 32'h0000_4000, MEM_LH, 32'h1234_8001, 32'hFFFF_8001, 0, 0, 1);
    run_load("lbu", 32'h0000_5001, MEM_LBU, 32'h0000_F700, 32'h0000_00F7, 2, 0, 0);
`ifdef LOAD_MISALIGN_CHECK_EN
    run_load("mis_lw", 32'h0000_6001, MEM_LW, 32'h1111_1111, 32'h0, 0, 0, 1);
`endif

    // Non-load request is ignored
    bus.ld_valid = 1'b1;
    bus.ld_type  = MEM_SW;
    bus.ld_addr  = 32'h0000_7000;
    tick();
    bus.ld_valid = 1'b0;
    chk("store.ready", bus.ld_ready, 1);
    chk("store.dreq", bus.dreq_valid, 0);

    // Flush in DATA, data_ok two cycles later
    bus.ld_valid = 1'b1; bus.ld_type = MEM_LW; bus.ld_addr = 32'h0000_8000;
    tick();
    bus.ld_valid = 1'b0;
    bus.dresp_addr_ok = 1'b1;
    tick();
    bus.dresp_addr_ok = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fdata.busy", bus.ld_ready, 0);
    chk("fdata.rv", bus.rd_valid, 0);
    tick();
    chk("fdata.busy2", bus.ld_ready, 0);
    bus.dresp_data_ok = 1'b1; bus.dresp_data = 32'h5555_AAAA;
    tick();
    bus.dresp_data_ok = 1'b0;
    chk("fdata.ready", bus.ld_ready, 1);
    chk("fdata.rv2", bus.rd_valid, 0);
    chk("fdata.dreq", bus.dreq_valid, 0);

    // Flush in ADDR before addr_ok
    bus.ld_valid = 1'b1; bus.ld_type = MEM_LH; bus.ld_addr = 32'h0000_9002;
    tick();
    bus.ld_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("faddr.dreq", bus.dreq_valid, 0);
    chk("faddr.ready", bus.ld_ready, 1);
    tick();
    chk("faddr.rv", bus.rd_valid, 0);

    // Flush in ADDR with addr_ok and data_ok together: straight back to IDLE
    bus.ld_valid = 1'b1; bus.ld_type = MEM_LB; bus.ld_addr = 32'h0000_A000;
    tick();
    bus.ld_valid = 1'b0;
    flush = 1'b1; bus.dresp_addr_ok = 1'b1; bus.dresp_data_ok = 1'b1;
    tick();
    flush = 1'b0; bus.dresp_addr_ok = 1'b0; bus.dresp_data_ok = 1'b0;
    chk("fboth.ready", bus.ld_ready, 1);
    chk("fboth.rv", bus.rd_valid, 0);

    // Flush in HOLD drops the result
    bus.ld_valid = 1'b1; bus.ld_type = MEM_LW; bus.ld_addr = 32'h0000_B000;
    tick();
    bus.ld_valid = 1'b0;
    bus.dresp_addr_ok = 1'b1; bus.dresp_data_ok = 1'b1; bus.dresp_data = 32'h0BAD_F00D;
    tick();
    bus.dresp_addr_ok = 1'b0; bus.dresp_data_ok = 1'b0;
    chk("fhold.rv", bus.rd_valid, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fhold.rv2", bus.rd_valid, 0);
    chk("fhold.ready", bus.ld_ready, 1);

    // Reset in the middle of a transaction
    bus.ld_valid = 1'b1; bus.ld_type = MEM_LW; bus.ld_addr = 32'h0000_C000;
    tick();
    bus.ld_valid = 1'b0;
    bus.dresp_addr_ok = 1'b1;
    tick();
    bus.dresp_addr_ok = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst.ready", bus.ld_ready, 1);
    chk("mrst.rv", bus.rd_valid, 0);
    chk("mrst.dreq", bus.dreq_valid, 0);
    chk("mrst.daddr", bus.dreq_addr, 0);

    // Randomized loads against the reference model
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      logic [31:0] w;
      mem_t        t;
      a = $urandom;
      w = $urandom;
      t = mem_t'($urandom_range(1, 5));
      run_load("rnd", a, t, w, model_data(a, t, w),
               $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
